keypad_scan: RTL

//  4x4 matrix-keypad scanner/debouncer; upstream stage feeding keypad decode/manage logic.

---
 rtl/kp_pkg.sv | 12 +
 rtl/key_debounce.sv | 53 +++++
 rtl/keypad_scan.sv | 69 ++++++
 3 files changed

// File: rtl/kp_pkg.sv
// Shared keypad geometry and the row/column to key-index mapping.
package kp_pkg;

   localparam int KP_ROWS = 4;
   localparam int KP_COLS = 4;
   localparam int KP_KEYS = KP_ROWS * KP_COLS;

   function automatic int key_idx(input int row_i, input int col_i);
      return row_i * KP_COLS + col_i;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: counts consecutive disagreeing samples and flips the
// debounced level after DB_CNT of them; pulses edge_pulse on a 0->1 flip.
module key_debounce #(
   parameter int DB_CNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_en,
   input  logic raw,
   output logic press,
   output logic edge_pulse
);

   localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;
   logic          edge_q, edge_d;

   always_comb begin
      cnt_d   = cnt_q;
      press_d = press_q;
      edge_d  = 1'b0;
      if (sample_en) begin
         if (raw == press_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            press_d = ~press_q;
            cnt_d   = '0;
            edge_d  = ~press_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         press_q <= 1'b0;
         edge_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         press_q <= press_d;
         edge_q  <= edge_d;
      end
   end

   assign press      = press_q;
   assign edge_pulse = edge_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: slot divider, one-hot-low column drive, two-stage row
// synchronizer and one debouncer per key, enabled only on its column's sample cycle.
module keypad_scan
   import kp_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int DB_CNT   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [KP_ROWS-1:0] row,
   output logic [KP_COLS-1:0] col,
   output logic [KP_KEYS-1:0] key_press,
   output logic [KP_KEYS-1:0] key_edge
);

   localparam int DW  = $clog2(SCAN_DIV);
   localparam int CIW = $clog2(KP_COLS);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [DW-1:0]      div_q, div_d;
   logic [CIW-1:0]     col_idx_q, col_idx_d;
   logic [KP_COLS-1:0] col_q, col_d;
   logic [KP_ROWS-1:0] row_m_q, row_s_q;
   logic               sample;

   always_comb begin
      sample    = (div_q == DIV_LAST);
      div_d     = sample ? '0 : div_q + DW'(1);
      col_idx_d = sample ? col_idx_q + CIW'(1) : col_idx_q;
      col_d     = ~(KP_COLS'(1) << col_idx_d);
   end

   // Rows idle high through the pull-ups, so the synchronizer resets to all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= '0;
         col_idx_q <= '0;
         col_q     <= ~KP_COLS'(1);
         row_m_q   <= '1;
         row_s_q   <= '1;
      end else begin
         div_q     <= div_d;
         col_idx_q <= col_idx_d;
         col_q     <= col_d;
         row_m_q   <= row;
         row_s_q   <= row_m_q;
      end
   end

   assign col = col_q;

   for (genvar r = 0; r < KP_ROWS; r++) begin : g_row
      for (genvar c = 0; c < KP_COLS; c++) begin : g_col
         localparam int K = key_idx(r, c);
         key_debounce #(
            .DB_CNT (DB_CNT)
         ) u_db (
            .clk        (clk),
            .rst        (rst),
            .sample_en  (sample && (col_idx_q == CIW'(c))),
            .raw        (~row_s_q[r]),
            .press      (key_press[K]),
            .edge_pulse (key_edge[K])
         );
      end
   end

endmodule
